// File: rtl/sccb_pkg.sv
// Shared types for the SCCB command sequencer.
// State encoding, master idle code and R/W bit values.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST1,
        S_A_ID,
        S_A_REG,
        S_A_DAT,
        S_W_IDL,
        S_ST2,
        S_A_RID,
        S_RD,
        S_W_DONE,
        S_RSP
    } seq_state_t;

    localparam logic [3:0] MASTER_IDLE = 4'd0;
    localparam logic       RW_WRITE    = 1'b0;
    localparam logic       RW_READ     = 1'b1;

    function automatic logic is_ack_state(input seq_state_t s);
        return (s == S_A_ID) || (s == S_A_REG) ||
               (s == S_A_DAT) || (s == S_A_RID);
    endfunction

endpackage

// File: rtl/sccb_watchdog.sv
// Per-state cycle counter for the command sequencer.
// Saturates; expired flags the last permitted cycle in a state.
module sccb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/sccb_cmd_seq.sv
// Register command sequencer in front of the SCCB/I2C byte master.
// Outputs are registered from the next state so they lead the master by one byte.
module sccb_cmd_seq
    import sccb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter bit          IGNORE_NACK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_id,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_tmo,
    output logic       m_start,
    output logic       m_stop,
    output logic [7:0] m_wr_data,
    input  logic [1:0] m_ack,
    input  logic       m_rd_tick,
    input  logic [7:0] m_rd_data,
    input  logic [3:0] m_state
);

    localparam bit ABORT_ON_NACK = !IGNORE_NACK;

    seq_state_t state_q, state_nx;

    logic       rw_q, rw_n;
    logic [6:0] id_q, id_n;
    logic [7:0] reg_q, reg_n;
    logic [7:0] wdata_q, wdata_n;
    logic [7:0] rd_q, rd_nx;
    logic       nack_q, nack_nx;
    logic       tmo_q, tmo_nx;
    logic       start_q, start_nx;
    logic       stop_q, stop_nx;
    logic [7:0] wr_q, wr_nx;
    logic       ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_rdata_q;

    logic accept;
    logic tick;
    logic nack_tick;
    logic abort;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign accept    = cmd_valid & ready_q;
    assign tick      = m_ack[1];
    assign nack_tick = tick & ~m_ack[0] & is_ack_state(state_q);
    assign abort     = ABORT_ON_NACK & nack_tick;
    assign wd_clear  = (state_nx != state_q);
    assign wd_enable = (state_q != S_IDLE);

    sccb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        rw_n     = accept ? cmd_rw    : rw_q;
        id_n     = accept ? cmd_id    : id_q;
        reg_n    = accept ? cmd_reg   : reg_q;
        wdata_n  = accept ? cmd_wdata : wdata_q;
        state_nx = state_q;
        rd_nx    = accept ? 8'h00 : rd_q;
        nack_nx  = accept ? 1'b0  : nack_q;
        tmo_nx   = accept ? 1'b0  : tmo_q;

        if (nack_tick) nack_nx = 1'b1;

        case (state_q)
            S_IDLE:   if (accept) state_nx = S_ST1;
            S_ST1:    if (m_state != MASTER_IDLE) state_nx = S_A_ID;
            S_A_ID:   if (tick) state_nx = S_A_REG;
            S_A_REG: begin
                if (tick) state_nx = (rw_q == RW_READ) ? S_W_IDL : S_A_DAT;
            end
            S_A_DAT:  if (tick) state_nx = S_W_DONE;
            S_W_IDL:  if (m_state == MASTER_IDLE) state_nx = S_ST2;
            S_ST2:    if (m_state != MASTER_IDLE) state_nx = S_A_RID;
            S_A_RID:  if (tick) state_nx = S_RD;
            S_RD: begin
                if (m_rd_tick) begin
                    rd_nx    = m_rd_data;
                    state_nx = S_W_DONE;
                end
            end
            S_W_DONE: if (m_state == MASTER_IDLE) state_nx = S_RSP;
            S_RSP:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase

        if (abort) state_nx = S_W_DONE;

        if (wd_expired) begin
            state_nx = S_RSP;
            tmo_nx   = 1'b1;
        end

        start_nx = 1'b0;
        stop_nx  = 1'b0;
        wr_nx    = 8'h00;
        case (state_nx)
            S_ST1: begin
                start_nx = 1'b1;
                wr_nx    = {id_n, RW_WRITE};
            end
            S_ST2: begin
                start_nx = 1'b1;
                wr_nx    = {id_n, RW_READ};
            end
            S_A_ID: wr_nx = reg_n;
            S_A_REG: begin
                if (rw_n == RW_READ) stop_nx = 1'b1;
                else                 wr_nx   = wdata_n;
            end
            S_A_DAT, S_RD: stop_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rw_q        <= RW_WRITE;
            id_q        <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            nack_q      <= 1'b0;
            tmo_q       <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            wr_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_nx;
            rw_q        <= rw_n;
            id_q        <= id_n;
            reg_q       <= reg_n;
            wdata_q     <= wdata_n;
            rd_q        <= rd_nx;
            nack_q      <= nack_nx;
            tmo_q       <= tmo_nx;
            start_q     <= start_nx;
            stop_q      <= stop_nx;
            wr_q        <= wr_nx;
            ready_q     <= (state_nx == S_IDLE);
            rsp_valid_q <= (state_nx == S_RSP);
            if (state_nx == S_RSP) rsp_rdata_q <= rd_nx;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = nack_q;
    assign rsp_tmo   = tmo_q;
    assign m_start   = start_q;
    // NACK abort must reach the master in the ack cycle itself
    assign m_stop    = stop_q | abort;
    assign m_wr_data = wr_q;

endmodule
